serial_frame_ctrl: RTL

- Sequencer for the serial-line sampling path. Detects a start bit, generates the mid-bit `sample_en` strobe that gates the negedge capture flops, and assembles a DATA_W-bit frame.
- Checks optional even parity and the stop bit, then presents the word over a valid/ack handshake.
- Sits between the raw `rx_d` line (already synchronised) and the consumer logic.

---
 rtl/serial_frame_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_frame_ctrl.sv
// Serial frame receiver: start detect, mid-bit sample strobe, LSB-first assembly, parity/stop check.
// First strobe div/2 cycles after start edge; valid the cycle after the stop strobe; held (no new frame) until ack.
module serial_frame_ctrl #(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 16,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_d,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              arm,
    input  logic              ack,
    output logic              sample_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;
    localparam logic [2:0] S_HOLD   = 3'd6;

    logic [2:0]        state;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_eff;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;
    logic              par_q;
    logic              active;

    assign div_eff   = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
    assign active    = (state == S_START) || (state == S_DATA) ||
                       (state == S_PARITY) || (state == S_STOP);
    assign busy      = (state != S_IDLE) && (state != S_ARMED);
    assign sample_en = active && (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            div_q      <= '0;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (active) begin
                if (cnt == '0) cnt <= div_q - DIV_W'(1);
                else           cnt <= cnt - DIV_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (arm) state <= S_ARMED;
                end
                S_ARMED: begin
                    if (!arm) begin
                        state <= S_IDLE;
                    end else if (!rx_d) begin
                        div_q <= div_eff;
                        cnt   <= (div_eff >> 1) - DIV_W'(1);
                        par_q <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    // A line that is high again at mid-bit was a glitch, not a start bit.
                    if (sample_en) begin
                        if (rx_d) begin
                            state <= S_ARMED;
                        end else begin
                            idx   <= '0;
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_en) begin
                        // Shifting in from the top leaves the first received bit at [0].
                        shreg <= {rx_d, shreg[DATA_W-1:1]};
                        idx   <= idx + IDX_W'(1);
                        if (idx == IDX_W'(DATA_W - 1))
                            state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (sample_en) begin
                        par_q <= (^shreg) ^ rx_d;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (sample_en) begin
                        frame_err  <= ~rx_d;
                        parity_err <= par_q;
                        data_out   <= shreg;
                        valid      <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ack) begin
                        valid      <= 1'b0;
                        parity_err <= 1'b0;
                        frame_err  <= 1'b0;
                        state      <= arm ? S_ARMED : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
